alu_sequencer: RTL

- Parametrised, registered successor to the combinational opcode-to-enable ALU decoder.
- Accepts one opcode per request through a valid/ready handshake and drives a one-hot operation vector to the datapath.
- Holds the vector for the op's latency: single-cycle for most ops, MUL_LAT cycles for MUL, DIV_LAT cycles for DIV/MOD.
- Reports done, illegal opcode and busy.
- Sits between the instruction decode stage and the ALU datapath.

---
 rtl/alu_sequencer.sv | 133 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Registered ALU operation sequencer: accepts one opcode per valid/ready handshake
// and holds a one-hot op_sel vector for the op's latency (MUL/DIV/MOD are multi-cycle).
module alu_sequencer #(
    parameter int unsigned OP_W    = 5,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 16,
    parameter int unsigned CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic            alu_enable,
    input  logic            flush,
    output logic            req_ready,
    output logic [14:0]     op_sel,
    output logic            imm,
    output logic            alu_busy,
    output logic            done,
    output logic            illegal
);

    typedef enum logic [0:0] {StIdle, StExec} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [14:0]      op_sel_q, op_sel_d;
    logic             imm_q, imm_d;
    logic             illegal_q, illegal_d;

    logic [4:0]       code;
    logic [14:0]      dec_sel;
    logic             dec_imm;
    logic             dec_legal;
    logic [CNT_W-1:0] dec_lat;
    logic             last;
    logic             accept;

    assign code = opcode[4:0];

    always_comb begin
        dec_sel   = '0;
        dec_imm   = 1'b0;
        dec_legal = 1'b1;
        dec_lat   = CNT_W'(1);
        case (code)
            5'b00001: dec_sel[0]  = 1'b1;
            5'b00010: dec_sel[1]  = 1'b1;
            5'b00011: begin dec_sel[2] = 1'b1; dec_lat = CNT_W'(MUL_LAT); end
            5'b00100: begin dec_sel[3] = 1'b1; dec_lat = CNT_W'(DIV_LAT); end
            5'b00101: begin dec_sel[4] = 1'b1; dec_lat = CNT_W'(DIV_LAT); end
            5'b00110: dec_sel[5]  = 1'b1;
            5'b00111: dec_sel[6]  = 1'b1;
            5'b01000: dec_sel[7]  = 1'b1;
            5'b01001: dec_sel[8]  = 1'b1;
            5'b01010: dec_sel[9]  = 1'b1;
            5'b01011: dec_sel[10] = 1'b1;
            5'b01100: dec_sel[11] = 1'b1;
            5'b01101: dec_sel[12] = 1'b1;
            5'b01110: dec_sel[13] = 1'b1;
            5'b01111: dec_sel[14] = 1'b1;
            5'b10010: begin dec_sel[0] = 1'b1; dec_imm = 1'b1; end
            5'b10011: begin dec_sel[1] = 1'b1; dec_imm = 1'b1; end
            5'b10100: begin dec_sel[2] = 1'b1; dec_imm = 1'b1; dec_lat = CNT_W'(MUL_LAT); end
            5'b10101: begin dec_sel[3] = 1'b1; dec_imm = 1'b1; dec_lat = CNT_W'(DIV_LAT); end
            5'b10110: begin dec_sel[8] = 1'b1; dec_imm = 1'b1; end
            5'b10111: begin dec_sel[9] = 1'b1; dec_imm = 1'b1; end
            default:  dec_legal = 1'b0;
        endcase
    end

    assign last      = (state_q == StExec) && (cnt_q == CNT_W'(1));
    assign req_ready = (state_q == StIdle) || (last && !flush);
    assign accept    = alu_enable && req_ready && !flush;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_sel_d  = op_sel_q;
        imm_d     = imm_q;
        illegal_d = 1'b0;
        if (flush) begin
            state_d  = StIdle;
            cnt_d    = '0;
            op_sel_d = '0;
            imm_d    = 1'b0;
        end else begin
            if (state_q == StExec) begin
                if (last) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    op_sel_d = '0;
                    imm_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            // An accept in EXEC can only happen on the final cycle, so it overrides the clear.
            if (accept) begin
                if (dec_legal) begin
                    state_d  = StExec;
                    cnt_d    = dec_lat;
                    op_sel_d = dec_sel;
                    imm_d    = dec_imm;
                end else begin
                    illegal_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_sel_q  <= '0;
            imm_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_sel_q  <= op_sel_d;
            imm_q     <= imm_d;
            illegal_q <= illegal_d;
        end
    end

    assign op_sel   = op_sel_q;
    assign imm      = imm_q;
    assign illegal  = illegal_q;
    assign alu_busy = (state_q == StExec);
    assign done     = last && !flush;

endmodule
